// File: rtl/product_accumulator_if.sv
// Handshake and data bundle between the multiplier/consumer side and the
// product accumulator. The accumulator connects through the slave modport;
// the driving side (multiplier, control logic and sum consumer) uses master.
interface product_accumulator_if #(
    parameter int BITS     = 4,
    parameter int ACC_BITS = 2*BITS+2,
    parameter int CNT_BITS = 3
);
    logic                  i_clear;
    logic                  i_product_valid;
    logic [2*BITS-1:0]     i_product;
    logic                  o_accept;
    logic [ACC_BITS-1:0]   o_sum;
    logic                  o_sum_valid;
    logic                  i_sum_ready;
    logic [CNT_BITS-1:0]   o_count;
    logic                  o_overflow;
    logic                  o_dropped;

    modport master (
        output i_clear, i_product_valid, i_product, i_sum_ready,
        input  o_accept, o_sum, o_sum_valid, o_count, o_overflow, o_dropped
    );

    modport slave (
        input  i_clear, i_product_valid, i_product, i_sum_ready,
        output o_accept, o_sum, o_sum_valid, o_count, o_overflow, o_dropped
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums a batch of TERMS unsigned products from the shift-add multiplier into a
// wide accumulator and offers the batch sum on a valid/ready handshake. While
// the sum waits for the consumer, o_accept is low so upstream withholds starts.
module product_accumulator #(
    parameter int BITS     = 4,
    parameter int TERMS    = 4,
    parameter int ACC_BITS = 2*BITS+2,
    parameter int CNT_BITS = $clog2(TERMS+1)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    product_accumulator_if.slave  bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TERMS);

    state_t               state;
    logic [ACC_BITS-1:0]  acc;
    logic [CNT_BITS-1:0]  count;
    logic                 overflow;
    logic                 dropped;
    logic [ACC_BITS:0]    sum_ext;
    logic [ACC_BITS-1:0]  product_ext;

    // Zero-extended product and the one-bit-wider sum whose MSB is the carry-out.
    always_comb begin
        product_ext = ACC_BITS'(bus.i_product);
        sum_ext     = {1'b0, acc} + {1'b0, product_ext};
    end

    // Batch FSM: accumulate in ACCUM, present the sum in HOLD until consumed.
    // NOTE: every register here is assigned with <= so all state updates on the
    // edge see the same pre-edge values, regardless of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset || bus.i_clear) begin
            state    <= ACCUM;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.i_product_valid) begin
                        acc      <= sum_ext[ACC_BITS-1:0];
                        overflow <= overflow | sum_ext[ACC_BITS];
                        count    <= count + CNT_ONE;
                        if (count + CNT_ONE == CNT_LAST) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.i_sum_ready) begin
                        overflow <= 1'b0;
                        dropped  <= 1'b0;
                        if (bus.i_product_valid) begin
                            // The product arriving with the handshake opens the next batch.
                            acc   <= product_ext;
                            count <= CNT_ONE;
                            state <= (TERMS == 1) ? HOLD : ACCUM;
                        end else begin
                            acc   <= '0;
                            count <= '0;
                            state <= ACCUM;
                        end
                    end else if (bus.i_product_valid) begin
                        dropped <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    // Outputs come straight from registers or a decode of the state.
    always_comb begin
        bus.o_sum       = acc;
        bus.o_count     = count;
        bus.o_overflow  = overflow;
        bus.o_dropped   = dropped;
        bus.o_sum_valid = (state == HOLD);
        bus.o_accept    = (state == ACCUM);
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator. Three instances cover the
// default configuration (TERMS=4), an 8-bit accumulator with TERMS=2 for
// overflow, and TERMS=1. Batch sums are queued when the closing product is
// driven and compared when the handshake consumes them.
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    product_accumulator_if #(.BITS(4), .ACC_BITS(10), .CNT_BITS(3)) bus_a ();
    product_accumulator_if #(.BITS(4), .ACC_BITS(8),  .CNT_BITS(2)) bus_b ();
    product_accumulator_if #(.BITS(4), .ACC_BITS(10), .CNT_BITS(1)) bus_c ();

    product_accumulator #(.BITS(4), .TERMS(4), .ACC_BITS(10), .CNT_BITS(3)) dut_a (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_a.slave)
    );

    product_accumulator #(.BITS(4), .TERMS(2), .ACC_BITS(8), .CNT_BITS(2)) dut_b (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_b.slave)
    );

    product_accumulator #(.BITS(4), .TERMS(1), .ACC_BITS(10), .CNT_BITS(1)) dut_c (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_c.slave)
    );

    int n_checks = 0;
    int n_passed = 0;

    int unsigned sb_a[$];
    int unsigned sb_c[$];
    int unsigned sb_a_exp;
    int unsigned sb_c_exp;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end else begin
            n_passed++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input bit pv, input int prod, input bit ready);
        bus_a.i_product_valid = pv;
        bus_a.i_product       = 8'(prod);
        bus_a.i_sum_ready     = ready;
        step();
    endtask

    task automatic b_drive(input bit pv, input int prod, input bit ready);
        bus_b.i_product_valid = pv;
        bus_b.i_product       = 8'(prod);
        bus_b.i_sum_ready     = ready;
        step();
    endtask

    task automatic c_drive(input bit pv, input int prod, input bit ready);
        bus_c.i_product_valid = pv;
        bus_c.i_product       = 8'(prod);
        bus_c.i_sum_ready     = ready;
        step();
    endtask

    // Scoreboard for instance A: a handshake happens on the coming edge.
    always @(negedge clk) begin
        if (!rst && !bus_a.i_clear && bus_a.o_sum_valid && bus_a.i_sum_ready) begin
            if (sb_a.size() == 0) begin
                check("a_sb_unexpected_sum", 32'(bus_a.o_sum), 32'hFFFF_FFFF);
            end else begin
                sb_a_exp = sb_a.pop_front();
                check("a_sb_sum", 32'(bus_a.o_sum), sb_a_exp);
            end
        end
    end

    // Scoreboard for instance C.
    always @(negedge clk) begin
        if (!rst && !bus_c.i_clear && bus_c.o_sum_valid && bus_c.i_sum_ready) begin
            if (sb_c.size() == 0) begin
                check("c_sb_unexpected_sum", 32'(bus_c.o_sum), 32'hFFFF_FFFF);
            end else begin
                sb_c_exp = sb_c.pop_front();
                check("c_sb_sum", 32'(bus_c.o_sum), sb_c_exp);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prods[4];
        int model;

        bus_a.i_clear = 1'b0; bus_a.i_product_valid = 1'b0; bus_a.i_product = '0; bus_a.i_sum_ready = 1'b0;
        bus_b.i_clear = 1'b0; bus_b.i_product_valid = 1'b0; bus_b.i_product = '0; bus_b.i_sum_ready = 1'b0;
        bus_c.i_clear = 1'b0; bus_c.i_product_valid = 1'b0; bus_c.i_product = '0; bus_c.i_sum_ready = 1'b0;

        // ---------------- Reset state ----------------
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_sum",      32'(bus_a.o_sum),       0);
        check("rst_valid",    32'(bus_a.o_sum_valid), 0);
        check("rst_accept",   32'(bus_a.o_accept),    1);
        check("rst_count",    32'(bus_a.o_count),     0);
        check("rst_overflow", 32'(bus_a.o_overflow),  0);
        check("rst_dropped",  32'(bus_a.o_dropped),   0);

        // ---------------- Basic batch, spaced products ----------------
        prods = '{143, 143, 195, 1};
        model = 0;
        for (int i = 0; i < 4; i++) begin
            a_drive(1'b1, prods[i], 1'b0);
            model += prods[i];
            check("basic_count", 32'(bus_a.o_count), i + 1);
            check("basic_sum", 32'(bus_a.o_sum), model);
            if (i == 3) begin
                sb_a.push_back(model);
            end else begin
                check("basic_accept_mid", 32'(bus_a.o_accept), 1);
                a_drive(1'b0, 0, 1'b0);
            end
        end
        check("basic_valid", 32'(bus_a.o_sum_valid), 1);
        check("basic_accept", 32'(bus_a.o_accept), 0);
        check("basic_sum_482", 32'(bus_a.o_sum), 482);
        check("basic_overflow", 32'(bus_a.o_overflow), 0);
        for (int i = 0; i < 3; i++) begin
            a_drive(1'b0, 0, 1'b0);
            check("hold_sum", 32'(bus_a.o_sum), 482);
            check("hold_valid", 32'(bus_a.o_sum_valid), 1);
            check("hold_count", 32'(bus_a.o_count), 4);
        end
        a_drive(1'b0, 0, 1'b1);
        check("hs_sum", 32'(bus_a.o_sum), 0);
        check("hs_accept", 32'(bus_a.o_accept), 1);
        check("hs_valid", 32'(bus_a.o_sum_valid), 0);
        check("hs_count", 32'(bus_a.o_count), 0);

        // ---------------- Back-to-back with ready held ----------------
        model = 0;
        for (int i = 0; i < 8; i++) begin
            a_drive(1'b1, 225, 1'b1);
            model = (i % 4 == 0) ? 225 : model + 225;
            check("b2b_dropped", 32'(bus_a.o_dropped), 0);
            check("b2b_sum", 32'(bus_a.o_sum), model);
            if (i % 4 == 3) begin
                sb_a.push_back(model);
                check("b2b_valid", 32'(bus_a.o_sum_valid), 1);
                check("b2b_sum_900", 32'(bus_a.o_sum), 900);
            end
            if (i == 4) begin
                check("b2b_restart_sum", 32'(bus_a.o_sum), 225);
                check("b2b_restart_count", 32'(bus_a.o_count), 1);
                check("b2b_restart_accept", 32'(bus_a.o_accept), 1);
            end
        end
        a_drive(1'b0, 0, 1'b1);
        check("b2b_end_sum", 32'(bus_a.o_sum), 0);
        check("b2b_end_accept", 32'(bus_a.o_accept), 1);

        // ---------------- Drop in HOLD ----------------
        prods = '{10, 20, 30, 40};
        for (int i = 0; i < 4; i++) begin
            a_drive(1'b1, prods[i], 1'b0);
        end
        sb_a.push_back(100);
        check("drop_pre_dropped", 32'(bus_a.o_dropped), 0);
        a_drive(1'b1, 50, 1'b0);
        check("drop_dropped", 32'(bus_a.o_dropped), 1);
        check("drop_sum", 32'(bus_a.o_sum), 100);
        check("drop_count", 32'(bus_a.o_count), 4);
        check("drop_valid", 32'(bus_a.o_sum_valid), 1);
        a_drive(1'b0, 0, 1'b1);
        check("drop_cleared", 32'(bus_a.o_dropped), 0);
        check("drop_hs_sum", 32'(bus_a.o_sum), 0);

        // ---------------- Clear mid-batch, reset in HOLD ----------------
        a_drive(1'b1, 7, 1'b0);
        a_drive(1'b1, 9, 1'b0);
        check("clr_pre_count", 32'(bus_a.o_count), 2);
        check("clr_pre_sum", 32'(bus_a.o_sum), 16);
        bus_a.i_clear = 1'b1;
        a_drive(1'b1, 99, 1'b0);
        bus_a.i_clear = 1'b0;
        check("clr_count", 32'(bus_a.o_count), 0);
        check("clr_sum", 32'(bus_a.o_sum), 0);
        check("clr_accept", 32'(bus_a.o_accept), 1);
        for (int i = 0; i < 4; i++) begin
            a_drive(1'b1, 1, 1'b0);
        end
        check("rsthold_pre_valid", 32'(bus_a.o_sum_valid), 1);
        check("rsthold_pre_sum", 32'(bus_a.o_sum), 4);
        rst = 1'b1;
        a_drive(1'b1, 5, 1'b1);
        rst = 1'b0;
        check("rsthold_valid", 32'(bus_a.o_sum_valid), 0);
        check("rsthold_accept", 32'(bus_a.o_accept), 1);
        check("rsthold_sum", 32'(bus_a.o_sum), 0);
        check("rsthold_count", 32'(bus_a.o_count), 0);
        a_drive(1'b0, 0, 1'b0);
        check("a_sb_drained", sb_a.size(), 0);

        // ---------------- Overflow: ACC_BITS=8, TERMS=2 ----------------
        b_drive(1'b1, 200, 1'b0);
        check("ovf_first_sum", 32'(bus_b.o_sum), 200);
        check("ovf_first_flag", 32'(bus_b.o_overflow), 0);
        b_drive(1'b1, 100, 1'b0);
        check("ovf_sum", 32'(bus_b.o_sum), (200 + 100) % 256);
        check("ovf_flag", 32'(bus_b.o_overflow), 1);
        check("ovf_valid", 32'(bus_b.o_sum_valid), 1);
        b_drive(1'b0, 0, 1'b0);
        check("ovf_hold_flag", 32'(bus_b.o_overflow), 1);
        check("ovf_hold_sum", 32'(bus_b.o_sum), 44);
        b_drive(1'b0, 0, 1'b1);
        check("ovf_cleared", 32'(bus_b.o_overflow), 0);
        check("ovf_hs_sum", 32'(bus_b.o_sum), 0);
        check("ovf_hs_accept", 32'(bus_b.o_accept), 1);

        // ---------------- TERMS=1 ----------------
        c_drive(1'b1, 77, 1'b0);
        sb_c.push_back(77);
        check("t1_valid", 32'(bus_c.o_sum_valid), 1);
        check("t1_sum", 32'(bus_c.o_sum), 77);
        check("t1_count", 32'(bus_c.o_count), 1);
        check("t1_accept", 32'(bus_c.o_accept), 0);
        prods = '{5, 250, 13, 128};
        for (int i = 0; i < 4; i++) begin
            c_drive(1'b1, prods[i], 1'b1);
            sb_c.push_back(prods[i]);
            check("t1_track_sum", 32'(bus_c.o_sum), prods[i]);
            check("t1_track_valid", 32'(bus_c.o_sum_valid), 1);
            check("t1_track_dropped", 32'(bus_c.o_dropped), 0);
        end
        c_drive(1'b0, 0, 1'b1);
        check("t1_end_valid", 32'(bus_c.o_sum_valid), 0);
        check("t1_end_accept", 32'(bus_c.o_accept), 1);
        check("t1_end_sum", 32'(bus_c.o_sum), 0);
        check("c_sb_drained", sb_c.size(), 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end
endmodule
